// File: rtl/wb_capture_seq_if.sv
// wb_capture_seq_if: Wishbone bus bundle (classic cycles) between CPU master and wb_capture_seq
// Signals keep the Wishbone slave-side names: wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i
// flow master->slave, wb_dat_o/ack_o/err_o flow slave->master.
interface wb_capture_seq_if #(parameter int WB_DW = 32);
  logic [4:0]       wb_adr_i;
  logic [WB_DW-1:0] wb_dat_i;
  logic [WB_DW/8-1:0] wb_sel_i;
  logic             wb_we_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic [2:0]       wb_cti_i;
  logic [1:0]       wb_bte_i;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_ack_o;
  logic             wb_err_o;
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_capture_seq.sv
// wb_capture_seq: Wishbone-configured frame capture sequencer (N frames, decimation, continuous, abort, irq)
// Ports: wb_clk_i/wb_rst_ni (async active-low), bus (wb_capture_seq_if.slave register port),
// frame_start (async v_sync level), capture_done (frame-complete pulse), enable (capture enable), irq_o (level irq).
// Registers: 0 CTRL, 1 NFRAMES, 2 DECIM, 3 STATUS (W1C), 4 FRAMES (RO), 5 TIMEOUT (only with CAPTURE_TIMEOUT_EN).
module wb_capture_seq #(
  parameter int WB_DW       = 32,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  wb_capture_seq_if.slave bus,
  input  logic           frame_start,
  input  logic           capture_done,
  output logic           enable,
  output logic           irq_o
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SKIP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic ack, cont, irq_en;
  logic [CNT_W-1:0] nframes, decim, frames, work_n, work_d, skip_cnt, frames_inc, n_eff;
  logic [2:0] status, idx;
  logic wr, arm, abort, fe, done_hit, unused_bits;
  logic [WB_DW-1:0] rd;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] timeout, tcnt;
`endif
  assign idx = bus.wb_adr_i[4:2];
  assign wr = ack & bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
  assign arm = wr && idx == 3'd0 && bus.wb_dat_i[0];
  assign abort = wr && idx == 3'd0 && bus.wb_dat_i[1];
  // the last sync stage doubles as the delayed copy, so the edge is seen one stage early
  // and enable can rise on exactly the SYNC_STAGES-th edge after frame_start is sampled
  assign fe = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
  assign frames_inc = &frames ? frames : frames + CNT_W'(1);
  assign n_eff = work_n == '0 ? CNT_W'(1) : work_n;
  assign done_hit = ~cont && frames_inc >= n_eff;
  assign bus.wb_ack_o = ack;
  assign bus.wb_err_o = 1'b0;
  assign bus.wb_dat_o = rd;
  assign unused_bits = ^{bus.wb_sel_i, bus.wb_cti_i, bus.wb_bte_i, bus.wb_adr_i[1:0], bus.wb_dat_i};
  always_comb begin
    rd = '0;
    case (idx)
      3'd0: rd[3:0] = {irq_en, cont, enable, state == ARMED || state == SKIP};
      3'd1: rd[CNT_W-1:0] = nframes;
      3'd2: rd[CNT_W-1:0] = decim;
      3'd3: rd[2:0] = status;
      3'd4: rd[CNT_W-1:0] = frames;
`ifdef CAPTURE_TIMEOUT_EN
      3'd5: rd[31:0] = timeout;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      sync <= '0;
      ack <= 1'b0;
      cont <= 1'b0;
      irq_en <= 1'b0;
      nframes <= '0;
      decim <= '0;
      frames <= '0;
      work_n <= '0;
      work_d <= '0;
      skip_cnt <= '0;
      status <= '0;
      enable <= 1'b0;
      irq_o <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      timeout <= '0;
      tcnt <= '0;
`endif
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], frame_start};
      ack <= bus.wb_cyc_i & bus.wb_stb_i & ~ack;
      irq_o <= irq_en & |status;
      if (wr)
        case (idx)
          3'd0: {irq_en, cont} <= bus.wb_dat_i[3:2];
          3'd1: nframes <= bus.wb_dat_i[CNT_W-1:0];
          3'd2: decim <= bus.wb_dat_i[CNT_W-1:0];
          3'd3: status <= status & ~bus.wb_dat_i[2:0];
`ifdef CAPTURE_TIMEOUT_EN
          3'd5: timeout <= bus.wb_dat_i[31:0];
`endif
          default: ;
        endcase
      // status bit sets below come later in the block so a set beats a same-cycle W1C
      if (abort) begin
        state <= IDLE;
        enable <= 1'b0;
      end else
        case (state)
          IDLE:
            if (arm) begin
              work_n <= nframes;
              work_d <= decim;
              frames <= '0;
              state <= ARMED;
            end
          ARMED:
            if (fe) begin
              state <= CAPTURE;
              enable <= 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
              tcnt <= 32'd1;
`endif
            end
          CAPTURE: begin
            if (fe) status[1] <= 1'b1;
            if (capture_done) begin
              frames <= frames_inc;
              enable <= 1'b0;
              if (done_hit) begin
                state <= IDLE;
                status[0] <= 1'b1;
              end else if (work_d == '0) state <= ARMED;
              else begin
                state <= SKIP;
                skip_cnt <= work_d;
              end
            end
`ifdef CAPTURE_TIMEOUT_EN
            else if (timeout != '0 && tcnt == timeout) begin
              state <= IDLE;
              enable <= 1'b0;
              status[2] <= 1'b1;
            end else tcnt <= tcnt + 32'd1;
`endif
          end
          SKIP:
            if (fe) begin
              if (skip_cnt == CNT_W'(1)) state <= ARMED;
              else skip_cnt <= skip_cnt - CNT_W'(1);
            end
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: doc/wb_capture_seq.md
Name: wb_capture_seq

Overview:
- Wishbone-configured capture sequencer; successor to the single-shot capture-enable register block.
- Sits between the CPU Wishbone bus and the frame capture datapath.
- Once armed, it waits for a frame-start edge from the sensor clock domain and asserts `enable` for whole frames.
- Supports N frames per arm, frame decimation, continuous mode, abort, sticky status and an interrupt.

Parameters:
- WB_DW, 32, Wishbone data width (>= 32).
- CNT_W, 16, width of the frame-count and decimation registers (<= 16).
- SYNC_STAGES, 2, number of synchroniser flops on `frame_start` (>= 2).

Ports:
- wb_clk_i, in, 1, single clock for all logic.
- wb_rst_ni, in, 1, asynchronous active-low reset.
- wb_adr_i, in, 5, byte address; register index is wb_adr_i[4:2].
- wb_dat_i, in, WB_DW, write data.
- wb_sel_i, in, WB_DW/8, byte selects; ignored, full-word writes only.
- wb_we_i, in, 1, write enable.
- wb_cyc_i, in, 1, bus cycle.
- wb_stb_i, in, 1, strobe.
- wb_cti_i, in, 3, ignored.
- wb_bte_i, in, 2, ignored.
- wb_dat_o, out, WB_DW, read data.
- wb_ack_o, out, 1, acknowledge.
- wb_err_o, out, 1, tied 0.
- frame_start, in, 1, asynchronous v_sync-type level.
- capture_done, in, 1, single-cycle pulse from the datapath when the current frame is complete.
- enable, out, 1, capture enable to the datapath.
- irq_o, out, 1, level interrupt.

Behaviour:

Reset:
- All outputs 0; state IDLE; all registers and counters 0.

Bus:
- wb_ack_o rises the cycle after cyc&stb and is held for 1 cycle; no back-to-back acks.
- Writes commit at the clock edge ending the ack cycle.
- Reads are combinational from the address; unused bits and unmapped addresses read 0.

Registers:
- 0 CTRL
  - Write: b0 ARM (pulse), b1 ABORT (pulse), b2 CONT, b3 IRQ_EN.
  - Read: b0 armed (state ARMED or SKIP), b1 enable, b2 CONT, b3 IRQ_EN.
- 1 NFRAMES
  - CNT_W bits, frames per arm; a value of 0 is treated as 1.
- 2 DECIM
  - CNT_W bits, frames skipped between captured frames.
- 3 STATUS
  - b0 DONE, b1 OVERRUN, b2 TIMEOUT; all sticky.
  - Writing 1 to a bit clears it.
- 4 FRAMES
  - Read-only count of frames captured since the last ARM; saturates at all-ones.

Frame edge:
- Rising edge of the synchronised frame_start.
- `enable` rises on the SYNC_STAGES-th clock edge after the first edge that samples frame_start high.

State machine (IDLE, ARMED, CAPTURE, SKIP):
- IDLE
  - ARM loads NFRAMES and DECIM into working copies, clears FRAMES, and moves to ARMED.
- ARMED
  - Frame edge moves to CAPTURE; enable=1 from that edge.
- CAPTURE
  - On capture_done, FRAMES increments.
  - If FRAMES has reached NFRAMES and CONT=0: go to IDLE, enable=0, set DONE.
  - Otherwise, if DECIM=0: go to ARMED.
  - Otherwise: go to SKIP with skip counter = DECIM.
- SKIP
  - Each frame edge decrements the skip counter.
  - On the edge where the counter is 1, go to ARMED.
  - Net effect: exactly DECIM frames are skipped.
- CONT=1: the NFRAMES terminal check is suppressed; FRAMES keeps counting and saturates.

Boundary rules:
- Frame edge while in CAPTURE (including the same cycle as capture_done): set OVERRUN; the edge is not used for a capture.
- ABORT: from any state, go to IDLE; enable=0 on the next edge; DONE is not set.
- ABORT and ARM in the same write: ABORT wins.
- ARM while not IDLE: ignored.
- capture_done outside CAPTURE: ignored.
- Register writes to NFRAMES/DECIM during a sequence take effect only at the next ARM.
- Asynchronous reset mid-capture: enable drops immediately; all state is cleared.

Interrupt:
- irq_o = IRQ_EN & (DONE | OVERRUN | TIMEOUT), registered.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- With the macro defined:
  - Register 5 TIMEOUT is added (32 bit, R/W, reset 0).
  - A clock counter runs while in CAPTURE and is cleared on entry to CAPTURE.
  - If TIMEOUT is non-zero and the counter equals TIMEOUT: go to IDLE, enable=0, set STATUS.TIMEOUT.
- Without the macro:
  - Register 5 reads 0 and writes are ignored.
  - STATUS b2 is always 0; there is no counter logic.

Test Plan:
1. Reset then read all registers -> all read 0; enable=0, irq_o=0, wb_ack_o=0.
2. NFRAMES=1, DECIM=0, ARM; raise frame_start; pulse capture_done 50 cycles later -> enable high SYNC_STAGES edges after frame_start, low 1 cycle after capture_done; STATUS=0x1; FRAMES=1.
3. NFRAMES=3, DECIM=2, ARM, 12 frame edges with capture_done mid-frame -> captures on edges 1, 4 and 7 only; FRAMES=3; DONE set; enable stays 0 for edges 8–12.
4. CONT=1, DECIM=0, IRQ_EN=1; frame edge during CAPTURE -> OVERRUN set, irq_o=1; write STATUS=0x2 -> OVERRUN clears, irq_o=0.
5. ARM, frame edge, then write CTRL=0x3 mid-capture -> enable=0 next cycle, DONE=0, CTRL reads 0.
6. With CAPTURE_TIMEOUT_EN, TIMEOUT=100, no capture_done -> enable falls 100 cycles after rising, STATUS=0x4; without the macro, register 5 reads 0.
